mem_pwr_switch_ctrl: RTL and testbench

- Initiator-side controller for one memory power-switch cell. It drives the switch control, `VCTRL` (1 = domain off), and watches the cell's acknowledge (`VCTRL_BUF`) and feedback (`VCTRLFB` = ~`VCTRL`).
- Sequences isolation, the switch, and a settle time for a sleep/wake request from the power manager.
- Flags timeouts and inconsistent acknowledges.
- One instance per gated memory bank, in the always-on domain.

---
 rtl/mem_pwr_pkg.sv | 33 +++
 rtl/mem_pwr_switch_ctrl.sv | 111 +++++++++++
 tb/tb_mem_pwr_switch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pwr_pkg.sv
// Shared state encoding and default timing for memory power-switch sequencing.
// Imported by the switch controller, the power manager and the bench.
package mem_pwr_pkg;

    typedef enum logic [2:0] {
        S_ON,
        S_ISO_ON,
        S_SW_OFF,
        S_SETTLE_OFF,
        S_OFF,
        S_SW_ON,
        S_SETTLE_ON,
        S_ISO_OFF
    } mem_pwr_state_e;

    localparam int DEF_ISO_SETUP_CYCLES = 2;
    localparam int DEF_SETTLE_CYCLES    = 4;
    localparam int DEF_ACK_TIMEOUT      = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Never returns zero so the counter always has at least one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int w;
        w = $clog2(max3(a, b, c) + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_pwr_switch_ctrl.sv
// Sleep/wake sequencer for one memory power-switch cell: isolation, switch,
// acknowledge check with timeout, settle time and a sticky error flag.
module mem_pwr_switch_ctrl
    import mem_pwr_pkg::*;
#(
    parameter int ISO_SETUP_CYCLES = DEF_ISO_SETUP_CYCLES,
    parameter int SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
    parameter int ACK_TIMEOUT      = DEF_ACK_TIMEOUT,
    parameter int CNT_W            = cnt_width(ISO_SETUP_CYCLES, SETTLE_CYCLES, ACK_TIMEOUT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sleep_req_i,
    output logic sleep_ack_o,
    output logic iso_o,
    output logic sw_ctrl_o,
    input  logic sw_ack_i,
    input  logic sw_fb_i,
    output logic busy_o,
    output logic err_o,
    input  logic err_clr_i
);

    mem_pwr_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_restart;
    logic             err_set;
    logic             ack_ok;

    // A state that "counts N cycles" lasts N cycles; N = 0 still lasts one.
    function automatic logic elapsed(input logic [CNT_W-1:0] cnt, input int n);
        return (int'(cnt) + 1) >= n;
    endfunction

    assign ack_ok = (sw_ack_i == sw_ctrl_o) && (sw_fb_i == ~sw_ctrl_o);

    always_comb begin
        state_d     = state_q;
        err_set     = 1'b0;
        cnt_restart = 1'b0;
        case (state_q)
            S_ON: begin
                if (!ack_ok)     err_set = 1'b1;
                if (sleep_req_i) state_d = S_ISO_ON;
            end
            S_ISO_ON: begin
                if (elapsed(cnt_q, ISO_SETUP_CYCLES)) state_d = S_SW_OFF;
            end
            S_SW_OFF: begin
                if (ack_ok) begin
                    state_d = S_SETTLE_OFF;
                end else if (elapsed(cnt_q, ACK_TIMEOUT)) begin
                    err_set = 1'b1;
                    state_d = S_SW_ON;
                end
            end
            S_SETTLE_OFF: begin
                if (elapsed(cnt_q, SETTLE_CYCLES)) state_d = S_OFF;
            end
            S_OFF: begin
                if (!ack_ok)      err_set = 1'b1;
                if (!sleep_req_i) state_d = S_SW_ON;
            end
            S_SW_ON: begin
                // Keep retrying: isolation must not drop on an unpowered bank.
                if (ack_ok) begin
                    state_d = S_SETTLE_ON;
                end else if (elapsed(cnt_q, ACK_TIMEOUT)) begin
                    err_set     = 1'b1;
                    cnt_restart = 1'b1;
                end
            end
            S_SETTLE_ON: begin
                if (elapsed(cnt_q, SETTLE_CYCLES)) state_d = S_ISO_OFF;
            end
            S_ISO_OFF: begin
                if (elapsed(cnt_q, ISO_SETUP_CYCLES)) state_d = S_ON;
            end
            default: state_d = S_ON;
        endcase

        cnt_d = cnt_q;
        if ((state_d != state_q) || cnt_restart) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_ON;
            cnt_q       <= '0;
            sw_ctrl_o   <= 1'b0;
            iso_o       <= 1'b0;
            sleep_ack_o <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sw_ctrl_o   <= (state_d == S_SW_OFF) || (state_d == S_SETTLE_OFF) || (state_d == S_OFF);
            iso_o       <= (state_d != S_ON);
            sleep_ack_o <= (state_d == S_OFF);
            busy_o      <= (state_d != S_ON) && (state_d != S_OFF);
            err_o       <= err_set | (err_o & ~err_clr_i);
        end
    end

endmodule

// File: tb/tb_mem_pwr_switch_ctrl.sv
// Randomized bench for mem_pwr_switch_ctrl with a delayed switch-cell model and
// an event scoreboard of expected output transitions.
module tb_mem_pwr_switch_ctrl;
    import mem_pwr_pkg::*;

    localparam int I = (DEF_ISO_SETUP_CYCLES < 1) ? 1 : DEF_ISO_SETUP_CYCLES;
    localparam int S = (DEF_SETTLE_CYCLES < 1) ? 1 : DEF_SETTLE_CYCLES;
    localparam int T = (DEF_ACK_TIMEOUT < 1) ? 1 : DEF_ACK_TIMEOUT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sleep_req = 1'b0;
    logic err_clr = 1'b0;
    logic sleep_ack, iso, sw_ctrl, busy, err;
    logic sw_ack, sw_fb;

    mem_pwr_switch_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sleep_req_i(sleep_req),
        .sleep_ack_o(sleep_ack),
        .iso_o      (iso),
        .sw_ctrl_o  (sw_ctrl),
        .sw_ack_i   (sw_ack),
        .sw_fb_i    (sw_fb),
        .busy_o     (busy),
        .err_o      (err),
        .err_clr_i  (err_clr)
    );

    always #5 clk = ~clk;

    // Switch cell: ack/feedback follow VCTRL ack_k edges later.
    int         ack_k = 3;
    logic [7:0] hist = '0;
    logic       dly;
    bit         ack_stuck = 1'b0;
    bit         fb_glitch = 1'b0;
    always @(posedge clk) hist <= {hist[6:0], sw_ctrl};
    always_comb begin
        dly = sw_ctrl;
        if (ack_k > 0) dly = hist[ack_k-1];
    end
    assign sw_ack = ack_stuck ? 1'b0 : dly;
    assign sw_fb  = ~dly ^ fb_glitch;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit err_m  = 1'b0;

    typedef struct {
        int sig;
        int cyc;
        bit val;
    } ev_t;
    ev_t exp_q[$];

    function automatic string nm(input int s);
        case (s)
            0:       return "sw_ctrl_o";
            1:       return "iso_o";
            2:       return "sleep_ack_o";
            3:       return "busy_o";
            default: return "err_o";
        endcase
    endfunction

    task automatic push(input int sig, input int c, input bit v);
        exp_q.push_back('{sig: sig, cyc: c, val: v});
    endtask

    // Monitor: every output change must match the oldest expected event of that signal.
    bit         mon_en = 1'b0;
    logic [4:0] prev;
    logic [4:0] cur;
    int         idx;
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {err, busy, sleep_ack, iso, sw_ctrl};
            for (int s = 0; s < 5; s++) begin
                if (cur[s] !== prev[s]) begin
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (exp_q[j].sig == s) begin
                            idx = j;
                            break;
                        end
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL %s: changed to %0b at cycle %0d, no change expected", nm(s), cur[s], cyc);
                    end else begin
                        if (exp_q[idx].cyc != cyc || exp_q[idx].val !== cur[s]) begin
                            errors++;
                            $display("FAIL %s: got %0b at cycle %0d, expected %0b at cycle %0d",
                                     nm(s), cur[s], cyc, exp_q[idx].val, exp_q[idx].cyc);
                        end
                        exp_q.delete(idx);
                    end
                end
            end
            for (int j = exp_q.size() - 1; j >= 0; j--) begin
                if (exp_q[j].cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: expected change to %0b at cycle %0d, still %0b at cycle %0d",
                             nm(exp_q[j].sig), exp_q[j].val, exp_q[j].cyc, cur[exp_q[j].sig], cyc);
                    exp_q.delete(j);
                end
            end
            prev = cur;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_sleep();
        int n, a;
        n = cyc + 1;
        a = n + I + ack_k + 1 + S;
        push(1, n, 1'b1); push(3, n, 1'b1); push(0, n + I, 1'b1);
        push(2, a, 1'b1); push(3, a, 1'b0);
        sleep_req = 1'b1;
        wait_until(a);
    endtask

    task automatic do_wake();
        int n, d;
        n = cyc + 1;
        d = n + ack_k + 1 + S + I;
        push(0, n, 1'b0); push(2, n, 1'b0); push(3, n, 1'b1);
        push(1, d, 1'b0); push(3, d, 1'b0);
        sleep_req = 1'b0;
        wait_until(d);
    endtask

    // Request drops during ISO_ON: the sequence still reaches OFF, then wakes.
    task automatic do_toggle();
        int n, a, n2, d;
        n  = cyc + 1;
        a  = n + I + ack_k + 1 + S;
        n2 = a + 1;
        d  = n2 + ack_k + 1 + S + I;
        push(1, n, 1'b1); push(3, n, 1'b1); push(0, n + I, 1'b1);
        push(2, a, 1'b1); push(3, a, 1'b0);
        push(0, n2, 1'b0); push(2, n2, 1'b0); push(3, n2, 1'b1);
        push(1, d, 1'b0); push(3, d, 1'b0);
        sleep_req = 1'b1;
        @(negedge clk);
        sleep_req = 1'b0;
        wait_until(d);
    endtask

    // Ack stuck low while powering down: timeout, abort and repower.
    task automatic do_timeout();
        int n, e, to, d;
        n  = cyc + 1;
        e  = n + I;
        to = e + T;
        d  = to + ack_k + 1 + S + I;
        push(1, n, 1'b1); push(3, n, 1'b1); push(0, e, 1'b1);
        if (!err_m) push(4, to, 1'b1);
        push(0, to, 1'b0);
        push(1, d, 1'b0); push(3, d, 1'b0);
        err_m     = 1'b1;
        ack_stuck = 1'b1;
        sleep_req = 1'b1;
        @(negedge clk);
        sleep_req = 1'b0;
        wait_until(d);
        ack_stuck = 1'b0;
    endtask

    task automatic do_err(input bit set, input bit clr);
        bit nxt;
        nxt = set | (err_m & ~clr);
        if (nxt != err_m) push(4, cyc + 1, nxt);
        err_m     = nxt;
        fb_glitch = set;
        err_clr   = clr;
        @(negedge clk);
        fb_glitch = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic do_reset_mid();
        int n, r;
        n = cyc + 1;
        r = n + I + ack_k + 2;
        push(1, n, 1'b1); push(3, n, 1'b1); push(0, n + I, 1'b1);
        sleep_req = 1'b1;
        wait_until(r - 1);
        push(0, r, 1'b0); push(1, r, 1'b0); push(3, r, 1'b0);
        if (err_m) push(4, r, 1'b0);
        err_m     = 1'b0;
        rst       = 1'b1;
        sleep_req = 1'b0;
        repeat (ack_k + 2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_rst(input string name, input logic v);
        checks++;
        if (v !== 1'b0) begin
            errors++;
            $display("FAIL reset_%s: got %0b, expected 0", name, v);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk_rst("sw_ctrl_o", sw_ctrl);
        chk_rst("iso_o", iso);
        chk_rst("sleep_ack_o", sleep_ack);
        chk_rst("busy_o", busy);
        chk_rst("err_o", err);
        rst    = 1'b0;
        prev   = {err, busy, sleep_ack, iso, sw_ctrl};
        mon_en = 1'b1;
        idle(2);

        ack_k = 4;
        do_sleep();
        idle(5);
        do_wake();
        idle(8);

        ack_k = 2;
        do_timeout();
        idle(3);
        do_err(1'b0, 1'b1);
        idle(8);

        do_err(1'b1, 1'b0);
        idle(3);
        do_err(1'b0, 1'b1);
        idle(2);
        do_err(1'b1, 1'b1);
        idle(2);
        do_err(1'b1, 1'b1);
        do_err(1'b0, 1'b1);
        idle(8);

        ack_k = 3;
        do_reset_mid();
        idle(8);

        ack_k = 1;
        do_toggle();
        idle(8);

        for (int it = 0; it < 30; it++) begin
            ack_k = $urandom_range(0, 5);
            case ($urandom_range(0, 4))
                0: begin
                    do_sleep();
                    idle($urandom_range(0, 4));
                    if ($urandom_range(0, 1) == 1) do_err(1'b1, 1'b0);
                    do_wake();
                end
                1: do_toggle();
                2: begin
                    do_err(1'b1, 1'b0);
                    idle($urandom_range(0, 3));
                    do_err(1'b0, 1'b1);
                end
                3: do_err(1'b1, $urandom_range(0, 1) == 1);
                default: do_err(1'b0, 1'b1);
            endcase
            idle(8);
        end

        ack_k = 0;
        do_timeout();
        do_err(1'b0, 1'b1);
        idle(20);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
